// File: rtl/score_scan_driver_if.sv
// -----------------------------------------------------------------------------
// score_scan_driver_if
//
// Bundles the score/load handshake and the per-digit scan outputs of
// score_scan_driver into one interface.
//
//   value     [13:0]  binary score, sampled when a load is accepted
//   load              single-cycle conversion request
//   dp_mask   [3:0]   decimal point per digit (bit i <-> select i), live
//   busy              conversion in progress, load ignored while high
//   ovf               last accepted value was > 9999 and got clamped
//   select    [1:0]   active digit, 0 = ones (rightmost), 3 = thousands
//   digit_val [3:0]   BCD digit for select, always 0..9
//   dp                decimal point for select, active-high
//
// master: the score source / downstream consumer side (drives value, load,
//         dp_mask; observes the scan outputs).
// slave : the score_scan_driver itself.
// -----------------------------------------------------------------------------
interface score_scan_driver_if;
  logic [13:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        busy;
  logic        ovf;
  logic [1:0]  select;
  logic [3:0]  digit_val;
  logic        dp;

  modport master (
    output value, load, dp_mask,
    input  busy, ovf, select, digit_val, dp
  );

  modport slave (
    input  value, load, dp_mask,
    output busy, ovf, select, digit_val, dp
  );
endinterface : score_scan_driver_if

// File: rtl/score_scan_driver.sv
// -----------------------------------------------------------------------------
// score_scan_driver
//
// Converts a 14-bit binary score (clamped to 0..9999) to four BCD digits with
// a sequential shift-add-3 (double-dabble) engine, holds the result in a
// display register and time-multiplexes the four digits for a downstream
// seven-segment driver. The scan side never waits on the converter: a new
// score simply replaces the display register on the conversion's last edge.
//
// Parameters
//   REFRESH_DIV  src_clk cycles per digit slot (must be >= 2)
//
// Ports
//   src_clk      single clock, rising edge
//   src_rst      asynchronous, active-high reset
//   bus          score_scan_driver_if.slave (value/load/dp_mask in,
//                busy/ovf/select/digit_val/dp out, all outputs registered)
// -----------------------------------------------------------------------------
module score_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  src_clk,
  input  logic                  src_rst,
  score_scan_driver_if.slave    bus
);

  localparam int unsigned PRESC_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0]  LAST_ITER = 4'd13;
  localparam logic [13:0] MAX_SCORE = 14'd9999;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q,   state_d;
  logic [3:0]           iter_q,    iter_d;
  // {bcd[15:0], bin[13:0]}
  logic [29:0]          work_q,    work_d;
  logic                 busy_q,    busy_d;
  logic                 ovf_q,     ovf_d;
  logic [15:0]          disp_q,    disp_d;

  logic [PRESC_W-1:0]   presc_q,   presc_d;
  logic [1:0]           sel_q,     sel_d;
  logic [3:0]           digit_q,   digit_d;
  logic                 dp_q,      dp_d;

  // Working register after the add-3 correction and after the shift.
  logic [29:0]          work_adj;
  logic [29:0]          work_shl;
  logic                 tick;

  // ---------------------------------------------------------------------------
  // Double-dabble step: correct every BCD nibble that would overflow past 9
  // when doubled, then shift {bcd, bin} left so the bin MSB enters the bcd LSB.
  // A nibble is at most 9 going in, so the +3 never leaves 4 bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    work_adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_adj[14 + 4*i +: 4] >= 4'd5) begin
        work_adj[14 + 4*i +: 4] = work_adj[14 + 4*i +: 4] + 4'd3;
      end
    end
    work_shl = {work_adj[28:0], 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    work_d  = work_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          work_d  = {16'd0, (bus.value > MAX_SCORE) ? MAX_SCORE : bus.value};
          ovf_d   = (bus.value > MAX_SCORE);
          busy_d  = 1'b1;
          iter_d  = 4'd0;
          state_d = CONV;
        end
      end

      CONV: begin
        // A load arriving here is dropped, not queued.
        work_d = work_shl;
        iter_d = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          // Only a finished conversion ever reaches the display register.
          disp_d  = work_shl[29:14];
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan: prescaler defines the slot, select advances on its terminal count.
  // digit_val/dp are looked up with the select value being registered on the
  // same edge, so the three outputs always describe the same digit.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick    = (presc_q == PRESC_W'(REFRESH_DIV - 1));
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    sel_d   = tick ? sel_q + 2'd1 : sel_q;
    digit_d = disp_q[4*sel_d +: 4];
    dp_d    = bus.dp_mask[sel_d];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the display register is a plain 16-bit flop bank, not a memory, so
  // it is reset along with everything else; a reset must blank the display.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state_q <= IDLE;
      iter_q  <= 4'd0;
      work_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      presc_q <= '0;
      sel_q   <= 2'd0;
      digit_q <= 4'd0;
      dp_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of every other flop, independent of statement order.
      state_q <= state_d;
      iter_q  <= iter_d;
      work_q  <= work_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      digit_q <= digit_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;
  assign bus.select    = sel_q;
  assign bus.digit_val = digit_q;
  assign bus.dp        = dp_q;

endmodule : score_scan_driver
